lfsr_keystream_ctrl: RTL and testbench
======================================

# lfsr_keystream_ctrl

Sequencer and bit packer for the 89-bit Fibonacci LFSR keystream generator in the CMAC datapath. It accepts a parallel seed and loads it serially into the LFSR through the `load`/`loadIt`/`enable` controls. It then clocks a programmable warm-up, and packs the LFSR's serial `newBit` output into `OUT_W`-bit keystream words on a valid/ready stream. The LFSR itself is a separate instance; this block drives its controls and consumes its output.

## Interface
- `SEED_W`, 89: LFSR length; number of serial load cycles.
- `WARMUP`, 160: discarded LFSR clocks after load; 0 allowed, which skips the WARMUP state.
- `OUT_W`, 8: keystream word width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `seed_valid`  in  1  seed offered.
- `seed_ready`  out  1  high only in IDLE.
- `seed_data`  in  SEED_W  seed; bit 0 is the first bit shifted in.
- `abort`  in  1  return to IDLE from any state.
- `busy`  out  1  state != IDLE.
- `lfsr_load`  out  1  serial seed bit to the LFSR.
- `lfsr_loadIt`  out  1  selects `lfsr_load` as the LFSR feedback.
- `lfsr_enable`  out  1  LFSR shift enable.
- `lfsr_newBit`  in  1  current LFSR output bit (LFSR bit 0).
- `ks_valid`  out  1  keystream word valid.
- `ks_ready`  in  1  consumer accepts.
- `ks_data`  out  OUT_W  keystream word; first LFSR bit in the LSB.

## Operation
- States: IDLE, LOAD, WARMUP, RUN.
- **IDLE**
  - `seed_ready`=1.
  - When `seed_valid`: capture `seed_data` into `seed_sr`, clear counters, go to LOAD.
- **LOAD**
  - `lfsr_enable`=1, `lfsr_loadIt`=1, `lfsr_load`=`seed_sr[0]`.
  - `seed_sr` shifts right each cycle.
  - After SEED_W cycles the LFSR register equals `seed_data`.
  - Go to WARMUP, or to RUN if WARMUP=0.
- **WARMUP**
  - `lfsr_enable`=1, `lfsr_loadIt`=0; `lfsr_newBit` is ignored.
  - After WARMUP cycles, go to RUN.
- **RUN**
  - `lfsr_loadIt`=0.
  - `lfsr_enable` = (`bit_cnt` != OUT_W-1) || !`ks_valid` || `ks_ready`.
  - On each enabled cycle, `acc[bit_cnt]` <= `lfsr_newBit` and `bit_cnt` increments, wrapping at OUT_W.
  - On the wrap cycle, `ks_data` <= {`lfsr_newBit`, `acc[OUT_W-2:0]`} and `ks_valid` <= 1.
  - Output holding register is one word deep. `ks_valid` clears on `ks_ready` unless a new word lands on the same edge; simultaneous drain and refill keeps `ks_valid`=1 with the new data.
  - While `ks_valid` && !`ks_ready` with `bit_cnt`=OUT_W-1, the LFSR stalls and no bit is lost or duplicated.
  - `ks_data` is stable while `ks_valid` && !`ks_ready`.
  - RUN continues until `abort` or `reset`.
- **abort** (any state): next state IDLE; `ks_valid`, `bit_cnt`, `acc` cleared; the LFSR contents are left as-is. `abort` has priority over `seed_valid` in IDLE.
- `lfsr_load`=0 whenever `lfsr_loadIt`=0.

## Timing
- Reset values: state IDLE; `seed_ready`=1; `busy`=0; `lfsr_load`=0; `lfsr_loadIt`=0; `lfsr_enable`=0; `ks_valid`=0; `ks_data`=0; counters 0.
- All LFSR control outputs are combinational from state and registers; `lfsr_newBit` is sampled on the same edge the LFSR shifts.
- Seed accepted at edge T → LOAD during cycles T+1..T+SEED_W.
- WARMUP runs the following WARMUP cycles.
- First `ks_valid` rises at edge T+SEED_W+WARMUP+OUT_W when `ks_ready` is held high.
- Sustained throughput: one word per OUT_W cycles with `ks_ready`=1, no bubbles.
- `reset` or `abort` mid-LOAD or mid-WARMUP: IDLE next cycle; a later seed fully reloads the LFSR.

## Structure
- Shared package `cmac_pkg`:
  - state enum `ks_state_t`.
  - `LFSR_LEN`=89.
  - default `KS_WARMUP`.
- Natural sub-module: `ks_bit_packer`. It contains `acc`, `bit_cnt`, the output register and the stall logic, and has inputs `bit_in`, `bit_en`, `clr`.
- The top level holds the FSM, `seed_sr` and the load/warm-up counters, with counter width $clog2(max(SEED_W,WARMUP)+1).

## Test plan
- Seed=1, WARMUP=0, `ks_ready`=1 → first `ks_data`=0x01 at edge T+97; the next 3 words are 0x00.
- Seed=0 → every word 0x00, continuously, one word per 8 cycles.
- Random seed, WARMUP=160, random `ks_ready` backpressure → word stream matches the LFSR reference model (taps 0 and 51) bit-exactly; `ks_data` is stable while stalled.
- `ks_ready`=0 for 50 cycles in RUN → `lfsr_enable` is low from `bit_cnt`=7 onward; after release, the stream resumes with no gap or repeat.
- `abort` at cycle 40 of LOAD, then a new seed → `seed_ready` rises the next cycle; the output stream corresponds only to the new seed.
- `seed_valid` and `abort` together in IDLE → seed not taken; `busy` stays 0.

Source files
------------

// File: rtl/cmac_pkg.sv
// Shared types and constants for the CMAC keystream path.
// Holds the controller state type and LFSR sizing defaults.
package cmac_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WARMUP,
    S_RUN
  } ks_state_t;

  localparam int LFSR_LEN  = 89;
  localparam int KS_WARMUP = 160;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ks_bit_packer.sv
// Packs serial LFSR bits into words behind a one-deep output register.
// bit_take tells the controller when the LFSR may advance.
module ks_bit_packer
  import cmac_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             ks_ready,
  output logic             bit_take,
  output logic             ks_valid,
  output logic [OUT_W-1:0] ks_data
);

  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

  logic [CW-1:0]    bit_cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_nx;
  logic             last;

  assign last = (bit_cnt == LAST);

  // Only the word-completing bit has to wait for the holding register.
  assign bit_take = bit_en &&
                    (!last || !ks_valid || ks_ready);

  always_comb begin
    acc_nx          = acc;
    acc_nx[bit_cnt] = bit_in;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      bit_cnt  <= '0;
      acc      <= '0;
      ks_valid <= 1'b0;
    end else if (bit_take && last) begin
      bit_cnt  <= '0;
      acc      <= acc_nx;
      ks_valid <= 1'b1;
    end else begin
      if (bit_take) begin
        bit_cnt <= bit_cnt + 1'b1;
        acc     <= acc_nx;
      end
      if (ks_ready) ks_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ks_data <= '0;
    else if (!clr && bit_take && last) ks_data <= acc_nx;
  end

endmodule

// File: rtl/lfsr_keystream_ctrl.sv
// Seed loader, warm-up sequencer and word packer control
// for the external 89-bit Fibonacci LFSR.
module lfsr_keystream_ctrl
  import cmac_pkg::*;
#(
  parameter int SEED_W = LFSR_LEN,
  parameter int WARMUP = KS_WARMUP,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [SEED_W-1:0] seed_data,
  input  logic              abort,
  output logic              busy,
  output logic              lfsr_load,
  output logic              lfsr_loadIt,
  output logic              lfsr_enable,
  input  logic              lfsr_newBit,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [OUT_W-1:0]  ks_data
);

  localparam int CW = $clog2(max2(SEED_W, WARMUP) + 1);
  localparam logic [CW-1:0] LD_LAST = CW'(SEED_W - 1);
  localparam logic [CW-1:0] WU_LAST =
    CW'((WARMUP > 0) ? WARMUP - 1 : 0);

  ks_state_t         state;
  ks_state_t         state_nx;
  logic [SEED_W-1:0] seed_sr;
  logic [CW-1:0]     cnt;
  logic              bit_take;
  logic              counting;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (seed_valid) state_nx = S_LOAD;
      S_LOAD:
        if (cnt == LD_LAST)
          state_nx = (WARMUP == 0) ? S_RUN : S_WARMUP;
      S_WARMUP:
        if (cnt == WU_LAST) state_nx = S_RUN;
      S_RUN:
        state_nx = S_RUN;
      default:
        state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  assign counting    = (state == S_LOAD) ||
                       (state == S_WARMUP);
  assign seed_ready  = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign lfsr_loadIt = (state == S_LOAD);
  assign lfsr_load   = lfsr_loadIt && seed_sr[0];
  assign lfsr_enable = counting || bit_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      seed_sr <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      if (!counting || state_nx != state) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == S_IDLE && seed_valid && !abort)
        seed_sr <= seed_data;
      else if (state == S_LOAD)
        seed_sr <= seed_sr >> 1;
    end
  end

  ks_bit_packer #(
    .OUT_W(OUT_W)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .clr     (abort || state == S_IDLE),
    .bit_in  (lfsr_newBit),
    .bit_en  (state == S_RUN),
    .ks_ready(ks_ready),
    .bit_take(bit_take),
    .ks_valid(ks_valid),
    .ks_data (ks_data)
  );

endmodule

// File: tb/tb_lfsr_keystream_ctrl.sv
// Bench: two controllers (warm-up 0 and 160) each driving a modelled
// 89-bit LFSR, checked against a bit-sequence reference.
module tb_lfsr_keystream_ctrl;

  typedef logic [7:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_valid;
  logic [88:0] seed_data;
  logic        abort;
  logic        ks_ready;
  logic        rdy_rand = 1'b0;
  logic        rdy_fix  = 1'b1;

  logic       sr0, bz0, ld0, li0, en0, nb0, kv0;
  logic       sr1, bz1, ld1, li1, en1, nb1, kv1;
  logic [7:0] kd0, kd1;

  logic [88:0] lf0 = '0;
  logic [88:0] lf1 = '0;

  wq_t q0, q1;
  int  errors = 0;
  int  checks = 0;
  int  stall_bad0 = 0;
  int  stall_bad1 = 0;
  logic       pv0 = 1'b0, pv1 = 1'b0;
  logic [7:0] pd0 = '0, pd1 = '0;

  always #5 clk = ~clk;

  lfsr_keystream_ctrl #(.SEED_W(89), .WARMUP(0), .OUT_W(8)) dut0 (
    .clk(clk), .reset(reset),
    .seed_valid(seed_valid), .seed_ready(sr0),
    .seed_data(seed_data), .abort(abort), .busy(bz0),
    .lfsr_load(ld0), .lfsr_loadIt(li0), .lfsr_enable(en0),
    .lfsr_newBit(nb0), .ks_valid(kv0), .ks_ready(ks_ready),
    .ks_data(kd0)
  );

  lfsr_keystream_ctrl #(.SEED_W(89), .WARMUP(160), .OUT_W(8)) dut1 (
    .clk(clk), .reset(reset),
    .seed_valid(seed_valid), .seed_ready(sr1),
    .seed_data(seed_data), .abort(abort), .busy(bz1),
    .lfsr_load(ld1), .lfsr_loadIt(li1), .lfsr_enable(en1),
    .lfsr_newBit(nb1), .ks_valid(kv1), .ks_ready(ks_ready),
    .ks_data(kd1)
  );

  // The external LFSRs: shift right, feedback into bit 88.
  assign nb0 = lf0[0];
  assign nb1 = lf1[0];

  always @(posedge clk) begin
    if (en0) lf0 <= {li0 ? ld0 : (lf0[0] ^ lf0[51]), lf0[88:1]};
    if (en1) lf1 <= {li1 ? ld1 : (lf1[0] ^ lf1[51]), lf1[88:1]};
  end

  always @(negedge clk)
    ks_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;

  always @(posedge clk) begin
    if (kv0 && ks_ready) q0.push_back(kd0);
    if (kv1 && ks_ready) q1.push_back(kd1);
    if (pv0 && kd0 !== pd0) stall_bad0 <= stall_bad0 + 1;
    if (pv1 && kd1 !== pd1) stall_bad1 <= stall_bad1 + 1;
    pv0 <= kv0 && !ks_ready;
    pv1 <= kv1 && !ks_ready;
    pd0 <= kd0;
    pd1 <= kd1;
  end

  // Keystream as a bit sequence: s[i+89] = s[i] ^ s[i+51].
  function automatic wq_t ref_words(input logic [88:0] sd,
                                    input int wu, input int n);
    bit         s[$];
    wq_t        w;
    logic [7:0] b;
    for (int i = 0; i < 89; i++) s.push_back(sd[i]);
    for (int i = 0; s.size() < wu + 8 * n; i++)
      s.push_back(s[i] ^ s[i + 51]);
    for (int j = 0; j < n; j++) begin
      b = '0;
      for (int t = 0; t < 8; t++) b[t] = s[wu + 8 * j + t];
      w.push_back(b);
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_stream(input string tag, input wq_t got,
                            input logic [88:0] sd, input int wu);
    wq_t e;
    e = ref_words(sd, wu, got.size());
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(e[i]));
  endtask

  task automatic send_seed(input logic [88:0] sd);
    @(negedge clk);
    seed_data  = sd;
    seed_valid = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic wait_words(input string tag, input int n0,
                            input int n1, input int bound);
    int k;
    k = 0;
    while ((q0.size() < n0 || q1.size() < n1) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 64'(k < bound), 64'(1));
  endtask

  logic [88:0] sd;
  logic [7:0]  held;
  int          k;
  int          n0;

  initial begin
    reset      = 1'b1;
    seed_valid = 1'b0;
    seed_data  = '0;
    abort      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_seed_ready", 64'(sr0), 64'(1));
    chk("rst_busy", 64'(bz0), 64'(0));
    chk("rst_load", 64'(ld0), 64'(0));
    chk("rst_loadIt", 64'(li0), 64'(0));
    chk("rst_enable", 64'(en0), 64'(0));
    chk("rst_ks_valid", 64'(kv0), 64'(0));
    chk("rst_ks_data", 64'(kd0), 64'(0));
    chk("rst_busy_w", 64'(bz1), 64'(0));

    // Seed = 1, no warm-up: first word at edge T+97.
    send_seed(89'd1);
    chk("a_seed_ready", 64'(sr0), 64'(0));
    chk("a_busy", 64'(bz0), 64'(1));
    chk("a_loadIt", 64'(li0), 64'(1));
    chk("a_load", 64'(ld0), 64'(1));
    chk("a_enable", 64'(en0), 64'(1));
    k = 0;
    while (!kv0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("a_first_valid_edge", 64'(k), 64'(97));
    chk("a_first_word", 64'(kd0), 64'(8'h01));
    wait_words("a", 4, 0, 200);
    cmp_stream("a_words", q0, 89'd1, 0);
    do_abort();

    // Seed = 0: all-zero words, one every 8 cycles.
    send_seed(89'd0);
    wait_words("b", 2, 0, 300);
    n0 = q0.size();
    repeat (80) @(negedge clk);
    chk("b_rate", 64'(q0.size() - n0), 64'(10));
    cmp_stream("b_words", q0, 89'd0, 0);
    do_abort();

    // Random seed under random backpressure, then a long stall.
    sd = {25'($urandom), $urandom, $urandom};
    rdy_rand = 1'b1;
    send_seed(sd);
    wait_words("c", 30, 30, 4000);
    rdy_rand = 1'b0;
    rdy_fix  = 1'b0;
    repeat (50) @(negedge clk);
    chk("d_valid0", 64'(kv0), 64'(1));
    chk("d_valid1", 64'(kv1), 64'(1));
    chk("d_stall_en0", 64'(en0), 64'(0));
    chk("d_stall_en1", 64'(en1), 64'(0));
    held = kd1;
    repeat (5) @(negedge clk);
    chk("d_held", 64'(kd1), 64'(held));
    rdy_fix = 1'b1;
    repeat (60) @(negedge clk);
    chk("cd_stable0", 64'(stall_bad0), 64'(0));
    chk("cd_stable1", 64'(stall_bad1), 64'(0));
    cmp_stream("cd_w0", q0, sd, 0);
    cmp_stream("cd_w1", q1, sd, 160);
    do_abort();

    // Abort 40 cycles into LOAD, then reload with a new seed.
    send_seed({25'($urandom), $urandom, $urandom});
    repeat (39) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("e_seed_ready", 64'(sr0), 64'(1));
    chk("e_busy", 64'(bz1), 64'(0));
    q0.delete();
    q1.delete();
    sd = {25'($urandom), $urandom, $urandom};
    send_seed(sd);
    wait_words("e", 8, 8, 2000);
    cmp_stream("e_w0", q0, sd, 0);
    cmp_stream("e_w1", q1, sd, 160);
    do_abort();

    // Abort beats a simultaneous seed in IDLE.
    @(negedge clk);
    seed_data  = 89'd5;
    seed_valid = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
    abort      = 1'b0;
    chk("f_seed_ready", 64'(sr0), 64'(1));
    chk("f_busy0", 64'(bz0), 64'(0));
    chk("f_busy1", 64'(bz1), 64'(0));
    chk("f_loadIt", 64'(li0), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
